// File: rtl/fwrisc_wb_sram.sv
// fwrisc_wb_sram: single-port word SRAM behind a Wishbone slave port.
// Each request is sequenced IDLE -> (WAIT x WAIT_STATES) -> RESP. The
// request terminates with a one-cycle ack, or with err when it is out of range.
// Writes and read-data capture both happen on the edge that enters RESP.
// Optional feature macro: FWRISC_WB_SRAM_RANGE_CHECK_EN
//   defined   : addresses outside the window terminate with err, no write, dat_r = 0
//   undefined : no range check, index wraps modulo DEPTH_WORDS, err tied low
module fwrisc_wb_sram #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] wbs_adr,
  input  logic [31:0] wbs_dat_w,
  output logic [31:0] wbs_dat_r,
  input  logic        wbs_cyc,
  input  logic        wbs_stb,
  input  logic        wbs_we,
  input  logic [3:0]  wbs_sel,
  output logic        wbs_ack,
  output logic        wbs_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_r_q, dat_r_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic          req_s;
  logic [31:0]   offset_s;
  logic [AW-1:0] idx_s;
  logic          in_range_s;
  logic          enter_resp_s;
  logic          mem_we_s;

  assign req_s    = wbs_cyc & wbs_stb;
  assign offset_s = wbs_adr - BASE_ADDR;
  assign idx_s    = offset_s[AW+1:2];

`ifdef FWRISC_WB_SRAM_RANGE_CHECK_EN
  // Addresses below the base wrap to large offsets, so one unsigned compare covers both ends.
  assign in_range_s = ({1'b0, offset_s} < (33'(DEPTH_WORDS) << 2));
`else
  logic unused_adr_s;
  assign in_range_s   = 1'b1;
  assign unused_adr_s = ^{offset_s[31:AW+2], offset_s[1:0]};
`endif

  // State, counter and registered bus outputs; reset aborts any transfer in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_r_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_r_q <= dat_r_d;
    end
  end

  // Next-state logic: count down wait states and drop back if the master withdraws.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          if (WAIT_STATES == 32'd0) begin
            state_d = ST_RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES - 32'd1);
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      end
      ST_WAIT: begin
        if (!req_s) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        // A request still visible here is the tail of the current one.
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output logic: everything that lands on the edge entering RESP.
  always_comb begin
    enter_resp_s = (state_d == ST_RESP);
    mem_we_s     = enter_resp_s & wbs_we & in_range_s & reset;
    ack_d        = enter_resp_s & in_range_s;
`ifdef FWRISC_WB_SRAM_RANGE_CHECK_EN
    err_d        = enter_resp_s & ~in_range_s;
`else
    err_d        = 1'b0;
`endif
    if (enter_resp_s && !in_range_s) begin
      dat_r_d = 32'h0000_0000;
    end else if (enter_resp_s && !wbs_we) begin
      dat_r_d = mem_q[idx_s];
    end else begin
      dat_r_d = dat_r_q;
    end
  end

  // Byte-lane write port; memory is deliberately outside reset.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wbs_sel[i]) begin
          mem_q[idx_s][8*i +: 8] <= wbs_dat_w[8*i +: 8];
        end
      end
    end
  end

  assign wbs_ack   = ack_q;
  assign wbs_err   = err_q;
  assign wbs_dat_r = dat_r_q;

endmodule
